fp16_normalize_round: RTL and testbench

- Sequential post-adder stage of the IEEE-754 half-precision datapath.
- Consumes the raw 11-bit mantissa sum, carry-out and sticky bit produced by the mantissa add/subtract stage, together with the pre-add exponent and result sign.
- Normalizes, rounds to nearest-even and packs a 16-bit result.
- Uses a valid/ready handshake on both sides and handles one operation in flight.

---
 rtl/fp16_normalize_round.sv | 147 ++++++++++++++
 tb/tb_fp16_normalize_round.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/fp16_normalize_round.sv
// Post-adder normalize / round-to-nearest-even / pack stage for half precision.
// Define FP16_NORM_FAST_EN for single-cycle normalization via leading-zero count.
module fp16_normalize_round (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [10:0] Rm,
    input  logic        carry,
    input  logic        arround,
    input  logic [4:0]  exp_in,
    input  logic        sign_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic        inexact,
    output logic        overflow
);
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t      state, state_nxt;
    logic [11:0] m, m_nxt;
    logic [5:0]  e, e_nxt;
    logic        g, g_nxt, s, s_nxt, sgn, sgn_nxt;
    logic [15:0] res_nxt;
    logic        inx_nxt, ovf_nxt;

    // rounding datapath, only consumed in ROUND
    logic        inc;
    logic [11:0] sum;
    logic [10:0] mant;
    logic [5:0]  er;
    logic [15:0] packed_res;

`ifdef FP16_NORM_FAST_EN
    logic [3:0] lz, sh;
    logic [5:0] emax;

    always_comb begin
        lz = 4'd11;
        for (int i = 0; i <= 10; i++)
            if (m[i]) lz = 4'(10 - i);
        emax = e - 6'd1;
        sh   = ({2'b0, lz} <= emax) ? lz : emax[3:0];
    end
`endif

    always_comb begin
        inc = g & (s | m[0]);
        sum = {1'b0, m[10:0]} + {11'b0, inc};
        if (sum[11]) begin
            mant = sum[11:1];
            er   = e + 6'd1;
        end else begin
            mant = sum[10:0];
            er   = e;
        end
        // a subnormal that rounds up to 0x400 picks up exponent 1 through mant[10]
        if (er >= 6'd31)
            packed_res = {sgn, 5'h1f, 10'h0};
        else if (mant == 11'd0)
            packed_res = 16'h0000;
        else
            packed_res = {sgn, mant[10] ? er[4:0] : 5'd0, mant[9:0]};
    end

    always_comb begin
        state_nxt = state;
        m_nxt     = m;
        e_nxt     = e;
        g_nxt     = g;
        s_nxt     = s;
        sgn_nxt   = sgn;
        res_nxt   = result;
        inx_nxt   = inexact;
        ovf_nxt   = overflow;
        case (state)
            IDLE: if (in_valid) begin
                m_nxt     = {carry, Rm};
                e_nxt     = (exp_in == 5'd0) ? 6'd1 : {1'b0, exp_in};
                g_nxt     = 1'b0;
                s_nxt     = arround;
                sgn_nxt   = sign_in;
                state_nxt = NORM;
            end
            NORM: begin
                // e == 31 only from the load; ROUND saturates it to infinity
                if (e == 6'd31) begin
                    state_nxt = ROUND;
                end else if (m[11]) begin
                    m_nxt     = {1'b0, m[11:1]};
                    g_nxt     = m[0];
                    s_nxt     = s | g;
                    e_nxt     = e + 6'd1;
                    state_nxt = ROUND;
                end else if (m == 12'd0 || m[10] || e == 6'd1) begin
                    state_nxt = ROUND;
                end else begin
`ifdef FP16_NORM_FAST_EN
                    m_nxt     = {m[10:0], g} << (sh - 4'd1);
                    e_nxt     = e - {2'b0, sh};
                    g_nxt     = 1'b0;
                    state_nxt = ROUND;
`else
                    m_nxt     = {m[10:0], g};
                    g_nxt     = 1'b0;
                    e_nxt     = e - 6'd1;
`endif
                end
            end
            ROUND: begin
                res_nxt   = packed_res;
                inx_nxt   = g | s;
                ovf_nxt   = (er >= 6'd31);
                state_nxt = DONE;
            end
            DONE: if (out_ready) state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            m        <= '0;
            e        <= '0;
            g        <= 1'b0;
            s        <= 1'b0;
            sgn      <= 1'b0;
            result   <= '0;
            inexact  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_nxt;
            m        <= m_nxt;
            e        <= e_nxt;
            g        <= g_nxt;
            s        <= s_nxt;
            sgn      <= sgn_nxt;
            result   <= res_nxt;
            inexact  <= inx_nxt;
            overflow <= ovf_nxt;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
endmodule

// File: tb/tb_fp16_normalize_round.sv
// Directed plus randomized checks of fp16_normalize_round against an arithmetic reference.
module tb_fp16_normalize_round;
    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready;
    logic [10:0] Rm;
    logic        carry, arround, sign_in;
    logic [4:0]  exp_in;
    logic        out_valid, out_ready;
    logic [15:0] result;
    logic        inexact, overflow;

    int checks   = 0;
    int failures = 0;

    fp16_normalize_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Rm(Rm), .carry(carry), .arround(arround), .exp_in(exp_in),
        .sign_in(sign_in), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .inexact(inexact), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Value = {carry,Rm} * 2^(E-25); normalise so the leading one sits at 2^10,
    // never letting E drop below 1, then round half-to-even on the dropped bit.
    function automatic void ref_model(input logic [10:0] rm, input logic c, input logic a,
                                      input logic [4:0] ex, input logic sg,
                                      output logic [15:0] r, output logic inx,
                                      output logic ovf, output int lat);
        int mnt, e, grd, msb, shl;
        logic [4:0] ef;
        mnt = int'(c) * 2048 + int'(rm);
        e   = (ex == 5'd0) ? 1 : int'(ex);
        grd = 0;
        lat = 3;
        if (ex == 5'd31) begin
            r = {sg, 5'h1f, 10'h0}; ovf = 1'b1; inx = a;
            return;
        end
        if (mnt >= 2048) begin
            grd = mnt % 2;
            mnt = mnt / 2;
            e   = e + 1;
        end else if (mnt != 0) begin
            msb = 0;
            for (int i = 0; i < 11; i++) if ((mnt >> i) % 2 == 1) msb = i;
            shl = 10 - msb;
            if (shl > e - 1) shl = e - 1;
            mnt = mnt * (1 << shl);
            e   = e - shl;
`ifndef FP16_NORM_FAST_EN
            lat = 3 + shl;
`endif
        end
        if (grd == 1 && (a || mnt % 2 == 1)) mnt = mnt + 1;
        if (mnt == 2048) begin mnt = 1024; e = e + 1; end
        inx = (grd == 1) || a;
        ovf = (e >= 31);
        ef  = e[4:0];
        if (e >= 31)       r = {sg, 5'h1f, 10'h0};
        else if (mnt == 0) r = 16'h0000;
        else               r = {sg, (mnt >= 1024) ? ef : 5'd0, mnt[9:0]};
    endfunction

    task automatic run_op(input logic [10:0] rm, input logic c, input logic a,
                          input logic [4:0] ex, input logic sg, input int hold,
                          input string tag);
        logic [15:0] er;
        logic ei, eo;
        int el, lat;
        ref_model(rm, c, a, ex, sg, er, ei, eo, el);
        @(negedge clk);
        chk({tag, ".rdy_idle"}, 32'(in_ready), 32'd1);
        Rm = rm; carry = c; arround = a; exp_in = ex; sign_in = sg; in_valid = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, ".rdy_busy"}, 32'(in_ready), 32'd0);
        // garbage presented while busy must not disturb the operation
        Rm = 11'($urandom); carry = 1'($urandom); exp_in = 5'($urandom);
        arround = 1'($urandom); sign_in = 1'($urandom);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            #1;
        end
        chk({tag, ".lat"}, 32'(lat), 32'(el));
        chk({tag, ".result"}, 32'(result), 32'(er));
        chk({tag, ".inexact"}, 32'(inexact), 32'(ei));
        chk({tag, ".overflow"}, 32'(overflow), 32'(eo));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk({tag, ".hold_vld"}, {15'd0, out_valid, result}, {16'd1, er});
            chk({tag, ".hold_rdy"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, ".handoff"}, {30'd0, in_ready, out_valid}, 32'b10);
    endtask

    initial begin
        logic [10:0] rr;
        logic [4:0]  re;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Rm = '0; carry = 1'b0; arround = 1'b0; exp_in = '0; sign_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", {13'd0, in_ready, out_valid, inexact, overflow, result},
            {13'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        @(negedge clk);
        rst = 1'b0;

        run_op(11'h400, 1'b0, 1'b0, 5'd15, 1'b0, 0, "normal");
        run_op(11'h001, 1'b1, 1'b0, 5'd15, 1'b0, 0, "carry_tie");
        run_op(11'h001, 1'b0, 1'b0, 5'd15, 1'b0, 0, "deep_norm");
        run_op(11'h7ff, 1'b1, 1'b0, 5'd30, 1'b1, 0, "overflow");
        run_op(11'h000, 1'b0, 1'b0, 5'd15, 1'b1, 5, "zero_bp");
        run_op(11'h055, 1'b0, 1'b1, 5'd0,  1'b1, 0, "subnorm");
        run_op(11'h3ff, 1'b0, 1'b1, 5'd1,  1'b0, 0, "sub_to_norm");
        run_op(11'h123, 1'b0, 1'b1, 5'd31, 1'b0, 1, "inf_in");
        run_op(11'h003, 1'b1, 1'b1, 5'd7,  1'b0, 0, "carry_rnd");

        // abort mid-normalisation
        @(negedge clk);
        Rm = 11'h001; carry = 1'b0; arround = 1'b0; exp_in = 5'd15; sign_in = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_abort", {30'd0, in_ready, out_valid}, 32'b10);
        @(negedge clk);
        rst = 1'b0;
        run_op(11'h400, 1'b0, 1'b0, 5'd15, 1'b0, 0, "after_rst");

        for (int n = 0; n < 60; n++) begin
            rr = 11'($urandom) >> $urandom_range(0, 10);
            re = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
            run_op(rr, 1'($urandom), 1'($urandom), re, 1'($urandom),
                   $urandom_range(0, 2), "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
